// File: rtl/byte2parallel_rgb888_pkg.sv
// Shared constants for the 1-lane RGB888 byte packer and unpacker:
// DSI/CSI data-type codes and the byte-phase encoding.
package byte2parallel_rgb888_pkg;

    localparam logic [5:0] DT_VSYNC_START = 6'h01;
    localparam logic [5:0] DT_VSYNC_END   = 6'h11;
    localparam logic [5:0] DT_HSYNC_START = 6'h21;
    localparam logic [5:0] DT_HSYNC_END   = 6'h31;
    localparam logic [5:0] DT_RGB888      = 6'h3E;

    // Which colour byte of the current pixel is expected next.
    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

endpackage

// File: rtl/byte2parallel_rgb888_sync_decoder.sv
// Turns short-packet sync events into VSYNC/HSYNC levels.
// Levels change one cycle after the sp_valid strobe; unknown types are ignored.
module dsi_sync_decoder
    import byte2parallel_rgb888_pkg::*;
(
    input  logic       byte_clk,
    input  logic       reset,
    input  logic       sp_valid,
    input  logic [5:0] pkt_dt,
    output logic       vsync,
    output logic       hsync,
    output logic       line_start
);

    // Combinational strobe so the line pixel counter can clear in the same edge.
    assign line_start = sp_valid && (pkt_dt == DT_HSYNC_START);

    // Sync level registers, set/cleared by the matching short-packet codes.
    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            vsync <= 1'b0;
            hsync <= 1'b0;
        end else if (sp_valid) begin
            case (pkt_dt)
                DT_VSYNC_START: vsync <= 1'b1;
                DT_VSYNC_END:   vsync <= 1'b0;
                DT_HSYNC_START: hsync <= 1'b1;
                DT_HSYNC_END:   hsync <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/byte2parallel_rgb888.sv
// Rebuilds 24-bit RGB888 pixels plus DE/VSYNC/HSYNC from a single-lane
// byte stream. Payload bytes arrive R,G,B; a pixel is emitted one cycle after
// its B byte. Handshake: byte_en is a qualifier with no backpressure; a byte is
// consumed in every cycle where byte_en is high and an accepted packet is open.
module byte2parallel_rgb888
    import byte2parallel_rgb888_pkg::*;
#(
    parameter logic [5:0] dt       = DT_RGB888,
    parameter int         H_ACTIVE = 240,
    parameter int         CNT_W    = 12
) (
    input  logic             byte_clk,
    input  logic             reset,
    input  logic             byte_en,
    input  logic [7:0]       byte_data,
    input  logic [5:0]       pkt_dt,
    input  logic             sp_valid,
    input  logic             lp_start,
    input  logic             err_clr,
    output logic [23:0]      PIXDATA,
    output logic             pix_valid,
    output logic             DE,
    output logic             VSYNC,
    output logic             HSYNC,
    output logic [CNT_W-1:0] pix_cnt,
    output logic             err_partial,
    output logic             err_overrun
);

    localparam logic [CNT_W-1:0] H_LIMIT = CNT_W'(H_ACTIVE);

    phase_t     phase, phase_nxt;
    logic       in_pkt, in_pkt_nxt;
    logic       byte_en_d;
    logic [7:0] r_q, g_q;
    logic       cap_r, cap_g, pix_fire, set_partial, set_overrun;
    logic       line_start;
    logic       accept, pkt_end;

    dsi_sync_decoder u_sync (
        .byte_clk   (byte_clk),
        .reset      (reset),
        .sp_valid   (sp_valid),
        .pkt_dt     (pkt_dt),
        .vsync      (VSYNC),
        .hsync      (HSYNC),
        .line_start (line_start)
    );

    // A short packet in the same cycle wins; the long-packet header is dropped.
    assign accept      = lp_start && !sp_valid && (pkt_dt == dt);
    assign pkt_end     = in_pkt && byte_en_d && !byte_en;
    assign set_overrun = pix_fire && (pix_cnt >= H_LIMIT);
    assign DE          = in_pkt;

    // Packet/phase state register.
    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            phase  <= PH_R;
            in_pkt <= 1'b0;
        end else begin
            phase  <= phase_nxt;
            in_pkt <= in_pkt_nxt;
        end
    end

    // Next packet/phase state and the per-byte capture strobes.
    always_comb begin
        phase_nxt   = phase;
        in_pkt_nxt  = in_pkt;
        cap_r       = 1'b0;
        cap_g       = 1'b0;
        pix_fire    = 1'b0;
        set_partial = 1'b0;
        if (accept) begin
            in_pkt_nxt  = 1'b1;
            phase_nxt   = PH_R;
            set_partial = in_pkt && (phase != PH_R);
        end else if (pkt_end) begin
            in_pkt_nxt  = 1'b0;
            phase_nxt   = PH_R;
            set_partial = (phase != PH_R);
        end else if (byte_en && in_pkt) begin
            case (phase)
                PH_R: begin
                    cap_r     = 1'b1;
                    phase_nxt = PH_G;
                end
                PH_G: begin
                    cap_g     = 1'b1;
                    phase_nxt = PH_B;
                end
                PH_B: begin
                    pix_fire  = 1'b1;
                    phase_nxt = PH_R;
                end
                default: phase_nxt = PH_R;
            endcase
        end
    end

    // Pixel datapath: byte capture, pixel output, end-of-payload detection.
    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            byte_en_d <= 1'b0;
            r_q       <= 8'h00;
            g_q       <= 8'h00;
            PIXDATA   <= 24'h000000;
            pix_valid <= 1'b0;
        end else begin
            byte_en_d <= byte_en;
            pix_valid <= pix_fire;
            if (cap_r)    r_q     <= byte_data;
            if (cap_g)    g_q     <= byte_data;
            if (pix_fire) PIXDATA <= {r_q, g_q, byte_data};
        end
    end

    // Line pixel counter, saturating; cleared at line or packet start.
    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            pix_cnt <= '0;
        end else if (accept || line_start) begin
            pix_cnt <= '0;
        end else if (pix_fire && !(&pix_cnt)) begin
            pix_cnt <= pix_cnt + 1'b1;
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            err_partial <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_partial <= set_partial || (err_partial && !err_clr);
            err_overrun <= set_overrun || (err_overrun && !err_clr);
        end
    end

endmodule
